// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL phase detector slice.
// PFD state encoding, detector mode constants and a saturating increment.
package adpll_pkg;

  typedef enum logic [1:0] {
    PFD_IDLE = 2'b00,
    PFD_UP   = 2'b01,
    PFD_DN   = 2'b10
  } pfd_state_e;

  localparam int MODE_LINEAR   = 0;
  localparam int MODE_BANGBANG = 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Multi-flop synchroniser for an asynchronous clock-like input, followed by
// a rising-edge detector in the system clock domain.
module pfd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/pfd_phase_counter.sv
// Synchronous tri-state phase-frequency detector: measures ref/feedback edge
// spacing in system-clock cycles, reports signed error, cycle slips and lock.
module pfd_phase_counter
  import adpll_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_b,
  input  logic                    IN_clk,
  input  logic                    FB_clk,
  output logic                    flagU,
  output logic                    flagD,
  output logic signed [CNT_W-1:0] err,
  output logic                    err_valid,
  output logic                    slip,
  output logic                    locked
);

  localparam logic [CNT_W-1:0] ERR_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam int               LCW      = $clog2(LOCK_CNT + 1);
  localparam logic [LCW-1:0]   LOCK_TOP = LCW'(LOCK_CNT);

  logic e_ref, e_fb;

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
    .clk      (CLK),
    .rst_n    (RESET_b),
    .async_in (IN_clk),
    .rise     (e_ref)
  );

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fb (
    .clk      (CLK),
    .rst_n    (RESET_b),
    .async_in (FB_clk),
    .rise     (e_fb)
  );

  pfd_state_e              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
  logic                    upd, slip_n;
  logic signed [CNT_W-1:0] raw, err_d;

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), 32'(ERR_MAX)));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    upd     = 1'b0;
    slip_n  = 1'b0;
    raw     = '0;
    unique case (state)
      PFD_IDLE: begin
        if (e_ref && e_fb) begin
          upd = 1'b1;
        end else if (e_ref) begin
          state_n = PFD_UP;
          cnt_n   = CNT_W'(1);
        end else if (e_fb) begin
          state_n = PFD_DN;
          cnt_n   = CNT_W'(1);
        end
      end
      PFD_UP: begin
        if (e_fb) begin
          upd = 1'b1;
          raw = cnt;
          // a coincident reference edge opens the next measurement at once
          if (e_ref) begin
            state_n = PFD_UP;
            cnt_n   = CNT_W'(1);
          end else begin
            state_n = PFD_IDLE;
            cnt_n   = '0;
          end
        end else if (e_ref) begin
          upd    = 1'b1;
          slip_n = 1'b1;
          raw    = ERR_MAX;
          cnt_n  = CNT_W'(1);
        end else begin
          cnt_n = cnt_inc;
        end
      end
      PFD_DN: begin
        if (e_ref) begin
          upd = 1'b1;
          raw = '0 - cnt;
          if (e_fb) begin
            state_n = PFD_DN;
            cnt_n   = CNT_W'(1);
          end else begin
            state_n = PFD_IDLE;
            cnt_n   = '0;
          end
        end else if (e_fb) begin
          upd    = 1'b1;
          slip_n = 1'b1;
          raw    = '0 - ERR_MAX;
          cnt_n  = CNT_W'(1);
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = PFD_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    err_d = raw;
    if (MODE == MODE_BANGBANG) begin
      if (raw == '0)        err_d = '0;
      else if (raw[CNT_W-1]) err_d = '1;
      else                   err_d = CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_b) begin
    if (!RESET_b) begin
      state     <= PFD_IDLE;
      cnt       <= '0;
      err       <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
      flagU     <= 1'b0;
      flagD     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      err_valid <= upd;
      slip      <= slip_n;
      flagU     <= (state_n == PFD_UP);
      flagD     <= (state_n == PFD_DN);
      if (upd) err <= err_d;
    end
  end

  // magnitude is one bit wider so negating the most negative value cannot wrap
  logic [CNT_W:0] err_mag;
  logic           in_tol;
  logic [LCW-1:0] lock_cnt, lock_cnt_n;

  assign err_mag = err[CNT_W-1] ? ((CNT_W+1)'(0) - {err[CNT_W-1], err}) : {1'b0, err};
  assign in_tol  = (err_mag <= (CNT_W+1)'(LOCK_TOL));

  always_comb begin
    lock_cnt_n = lock_cnt;
    if (slip) begin
      lock_cnt_n = '0;
    end else if (err_valid) begin
      lock_cnt_n = in_tol ? LCW'(sat_inc(32'(lock_cnt), 32'(LOCK_CNT))) : '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_b) begin
    if (!RESET_b) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_n;
      locked   <= (lock_cnt_n == LOCK_TOP);
    end
  end

endmodule

// File: tb/tb_pfd_phase_counter.sv
// Scoreboard bench for pfd_phase_counter: linear and bang-bang instances
// share stimulus; expected errors are queued and checked on err_valid.
module tb_pfd_phase_counter;

  typedef struct {
    int   e;
    logic s;
    logic lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ref_clk = 1'b0;
  logic fb_clk = 1'b0;

  logic              flag_u0, flag_d0, valid0, slip0, locked0;
  logic signed [7:0] err0;
  logic              flag_u1, flag_d1, valid1, slip1, locked1;
  logic signed [7:0] err1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lcnt  = 0;

  always #5 clk = ~clk;

  pfd_phase_counter #(.CNT_W(8), .SYNC_STAGES(2), .MODE(0), .LOCK_TOL(1), .LOCK_CNT(16)) dut_lin (
    .CLK(clk), .RESET_b(rst_n), .IN_clk(ref_clk), .FB_clk(fb_clk),
    .flagU(flag_u0), .flagD(flag_d0), .err(err0), .err_valid(valid0),
    .slip(slip0), .locked(locked0)
  );

  pfd_phase_counter #(.CNT_W(8), .SYNC_STAGES(2), .MODE(1), .LOCK_TOL(1), .LOCK_CNT(16)) dut_bb (
    .CLK(clk), .RESET_b(rst_n), .IN_clk(ref_clk), .FB_clk(fb_clk),
    .flagU(flag_u1), .flagD(flag_d1), .err(err1), .err_valid(valid1),
    .slip(slip1), .locked(locked1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected linear error and slip; bang-bang error and lock state derived here
  task automatic push_exp(input int e, input logic s);
    exp_t a, b;
    if (s || e > 1 || e < -1) lcnt = 0;
    else if (lcnt < 16) lcnt++;
    a.e = e; a.s = s; a.lk = (lcnt == 16);
    b.e = (e > 0) ? 1 : ((e < 0) ? -1 : 0); b.s = s; b.lk = 1'b0;
    q0.push_back(a);
    q1.push_back(b);
  endtask

  task automatic run_pair(input int rd, input int fd);
    int nu, nd, last, e;
    e = fd - rd;
    push_exp(e, 1'b0);
    nu = 0; nd = 0;
    last = (rd > fd) ? rd : fd;
    for (int c = 0; c <= last + 8; c++) begin
      @(negedge clk);
      nu += int'(flag_u0);
      nd += int'(flag_d0);
      if (c == rd) ref_clk = 1'b1;
      if (c == fd) fb_clk = 1'b1;
    end
    ref_clk = 1'b0;
    fb_clk  = 1'b0;
    repeat (8) begin
      @(negedge clk);
      nu += int'(flag_u0);
      nd += int'(flag_d0);
    end
    chk("flagU_cycles", nu, (e > 0) ? e : 0);
    chk("flagD_cycles", nd, (e < 0) ? -e : 0);
  endtask

  // linear-instance monitor: error, slip, then lock state one cycle later
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && valid0) begin
        if (q0.size() == 0) begin
          chk("unexpected_valid_lin", 1, 0);
        end else begin
          x = q0.pop_front();
          chk("err_lin", int'(err0), x.e);
          chk("slip_lin", int'(slip0), int'(x.s));
          @(negedge clk);
          chk("locked_lin", int'(locked0), int'(x.lk));
        end
      end
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && valid1) begin
        if (q1.size() == 0) begin
          chk("unexpected_valid_bb", 1, 0);
        end else begin
          x = q1.pop_front();
          chk("err_bb", int'(err1), x.e);
          chk("slip_bb", int'(slip1), int'(x.s));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flagU", int'(flag_u0), 0);
    chk("rst_flagD", int'(flag_d0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_slip", int'(slip0), 0);
    chk("rst_locked", int'(locked0), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    repeat (3) run_pair(0, 5);
    repeat (2) run_pair(3, 0);
    repeat (2) run_pair(0, 0);

    // feedback stopped: every further reference edge is a slip
    push_exp(127, 1'b1);
    push_exp(127, 1'b1);
    push_exp(4, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 0 || c == 10 || c == 20) ref_clk = 1'b1;
      if (c == 4 || c == 14 || c == 24) ref_clk = 1'b0;
      if (c == 24) fb_clk = 1'b1;
      if (c == 30) fb_clk = 1'b0;
    end
    chk("locked_after_slip", int'(locked0), 0);
    repeat (4) @(negedge clk);

    repeat (16) run_pair(0, 1);
    chk("locked_after_16", int'(locked0), 1);
    run_pair(0, 4);
    chk("locked_after_big", int'(locked0), 0);

    // reset in the middle of an UP measurement
    @(negedge clk);
    ref_clk = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_flagU", int'(flag_u0), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flagU", int'(flag_u0), 0);
    chk("midrst_err", int'(err0), 0);
    chk("midrst_valid", int'(valid0), 0);
    chk("midrst_locked", int'(locked0), 0);
    chk("midrst_err_bb", int'(err1), 0);
    lcnt = 0;
    ref_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_pair(0, 2);

    repeat (10) @(negedge clk);
    chk("leftover_lin", q0.size(), 0);
    chk("leftover_bb", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
